// File: rtl/pool_pkg.sv
// Shared types and defaults for the per-PE pooling datapath.
// POOL_AVG_EN adds average pooling and a pool_type field in the config.
package pool_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MAX_ROW  = 256;
  localparam int DEF_MAX_POOL = 4;
  // Must match the pool sequencer's LAT_POOL
  localparam int LAT_POOL     = 2;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_type_e;

  typedef struct packed {
    logic [15:0] row_length;
    logic [3:0]  pool_horiz;
    logic [3:0]  pool_vert;
`ifdef POOL_AVG_EN
    pool_type_e  pool_type;
`endif
  } pool_cfg_t;

  function automatic logic is_pow2(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] pool_log2(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[3])      r = 2'd3;
    else if (v[2]) r = 2'd2;
    else if (v[1]) r = 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/pool_row_mem.sv
// 1R1W partial-result row memory, registered read port.
// A same-cycle write to the read address is forwarded to the read data.
module pool_row_mem #(
  parameter int W     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
      else                              rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pool_window_unit.sv
// Per-PE streaming pool window reducer: max pooling by default,
// average pooling as well when POOL_AVG_EN is defined.
module pool_window_unit
  import pool_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_ROW  = DEF_MAX_ROW,
  parameter int MAX_POOL = DEF_MAX_POOL
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_buffer_reset,
  input  logic                     pool_enable,
  input  logic                     shift_in,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic [15:0]              row_length,
  input  logic [3:0]               pool_horiz,
  input  logic [3:0]               pool_vert,
`ifdef POOL_AVG_EN
  input  logic                     pool_type,
`endif
  output logic signed [DATA_W-1:0] pool_out,
  output logic                     pool_out_valid,
  output logic                     cfg_err
);

`ifdef POOL_AVG_EN
  localparam int ACC_W = DATA_W + 4;
`else
  localparam int ACC_W = DATA_W;
`endif
  localparam int AW = $clog2(MAX_ROW);
  localparam logic [3:0]  MAXP = 4'(MAX_POOL);
  localparam logic [16:0] MAXR = 17'(MAX_ROW);

  pool_cfg_t   cfg_q, cfg_d;
  logic        err_q, err_d;
  logic [15:0] owid_q, owid_d;
`ifdef POOL_AVG_EN
  logic [2:0]  sh_q, sh_d;
`endif

  logic [15:0] col_q, col_d, wcol_q, wcol_d;
  logic [3:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic signed [ACC_W-1:0] hacc_q, hacc_d;

  logic          s2_v_q, s2_v_d;
  logic          s2_first_q, s2_first_d;
  logic          s2_last_q, s2_last_d;
  logic [AW-1:0] s2_addr_q, s2_addr_d;
  logic signed [ACC_W-1:0] s2_h_q, s2_h_d;

  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     valid_q, valid_d;

  logic avg, accept, col_last, h_last, v_last, in_win, win_done, we;
  logic signed [ACC_W-1:0] din_x, h_next, rdata, merged;
  logic signed [DATA_W-1:0] result;

  function automatic logic signed [ACC_W-1:0] merge(
    input logic                    is_avg,
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    if (is_avg) return a + b;
    return (a > b) ? a : b;
  endfunction

`ifdef POOL_AVG_EN
  logic signed [ACC_W-1:0] avg_sh;
  assign avg = (cfg_q.pool_type == POOL_AVG);
  assign avg_sh = merged >>> sh_q;
  assign result = avg ? avg_sh[DATA_W-1:0] : merged[DATA_W-1:0];
`else
  assign avg = 1'b0;
  assign result = merged;
`endif

  assign accept = shift_in & pool_enable & ~line_buffer_reset & ~err_q;
  assign col_last = (col_q == cfg_q.row_length - 16'd1);
  assign h_last = (hcnt_q == cfg_q.pool_horiz - 4'd1);
  assign v_last = (vcnt_q == cfg_q.pool_vert - 4'd1);
  assign in_win = (wcol_q < owid_q);
  assign win_done = accept & h_last & in_win;
  assign din_x = ACC_W'(data_in);
  assign h_next = (hcnt_q == 4'd0) ? din_x : merge(avg, hacc_q, din_x);
  assign merged = s2_first_q ? s2_h_q : merge(avg, rdata, s2_h_q);
  assign we = s2_v_q & ~s2_last_q & ~line_buffer_reset;

  // Config tracks the live inputs while line_buffer_reset is high,
  // so the value present as it falls is the one held for the frame.
  always_comb begin
    cfg_d = cfg_q;
    err_d = err_q;
    owid_d = owid_q;
`ifdef POOL_AVG_EN
    sh_d = sh_q;
`endif
    if (line_buffer_reset) begin
      cfg_d.row_length = row_length;
      cfg_d.pool_horiz = pool_horiz;
      cfg_d.pool_vert = pool_vert;
      err_d = (pool_horiz == 4'd0) || (pool_vert == 4'd0) ||
              (pool_horiz > MAXP) || (pool_vert > MAXP) ||
              ({1'b0, row_length} > MAXR) ||
              (row_length < {12'd0, pool_horiz});
      owid_d = (pool_horiz == 4'd0) ? 16'd0
             : row_length / {12'd0, pool_horiz};
`ifdef POOL_AVG_EN
      cfg_d.pool_type = pool_type_e'(pool_type);
      sh_d = {1'b0, pool_log2(pool_horiz)} + {1'b0, pool_log2(pool_vert)};
      if (pool_type && !(is_pow2(pool_horiz) && is_pow2(pool_vert)))
        err_d = 1'b1;
`endif
    end
  end

  always_comb begin
    col_d = col_q;
    hcnt_d = hcnt_q;
    wcol_d = wcol_q;
    vcnt_d = vcnt_q;
    hacc_d = hacc_q;
    s2_v_d = 1'b0;
    s2_first_d = s2_first_q;
    s2_last_d = s2_last_q;
    s2_addr_d = s2_addr_q;
    s2_h_d = s2_h_q;
    out_d = out_q;
    valid_d = 1'b0;
    if (line_buffer_reset) begin
      col_d = '0;
      hcnt_d = '0;
      wcol_d = '0;
      vcnt_d = '0;
    end else begin
      if (accept) begin
        hacc_d = h_next;
        col_d = col_last ? 16'd0 : col_q + 16'd1;
        hcnt_d = (col_last || h_last) ? 4'd0 : hcnt_q + 4'd1;
        if (col_last)    wcol_d = 16'd0;
        else if (h_last) wcol_d = wcol_q + 16'd1;
        if (col_last) vcnt_d = v_last ? 4'd0 : vcnt_q + 4'd1;
        if (h_last && in_win) begin
          s2_v_d = 1'b1;
          s2_first_d = (vcnt_q == 4'd0);
          s2_last_d = v_last;
          s2_addr_d = wcol_q[AW-1:0];
          s2_h_d = h_next;
        end
      end
      // Final row of the window bypasses memory into the output
      if (s2_v_q && s2_last_q && !err_q) begin
        out_d = result;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_q <= '0;
      err_q <= 1'b0;
      owid_q <= '0;
`ifdef POOL_AVG_EN
      sh_q <= '0;
`endif
      col_q <= '0;
      hcnt_q <= '0;
      wcol_q <= '0;
      vcnt_q <= '0;
      hacc_q <= '0;
      s2_v_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q <= 1'b0;
      s2_addr_q <= '0;
      s2_h_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      err_q <= err_d;
      owid_q <= owid_d;
`ifdef POOL_AVG_EN
      sh_q <= sh_d;
`endif
      col_q <= col_d;
      hcnt_q <= hcnt_d;
      wcol_q <= wcol_d;
      vcnt_q <= vcnt_d;
      hacc_q <= hacc_d;
      s2_v_q <= s2_v_d;
      s2_first_q <= s2_first_d;
      s2_last_q <= s2_last_d;
      s2_addr_q <= s2_addr_d;
      s2_h_q <= s2_h_d;
      out_q <= out_d;
      valid_q <= valid_d;
    end
  end

  pool_row_mem #(
    .W    (ACC_W),
    .DEPTH(MAX_ROW),
    .AW   (AW)
  ) u_row_mem (
    .clk_i  (clk),
    .re_i   (win_done),
    .raddr_i(wcol_q[AW-1:0]),
    .rdata_o(rdata),
    .we_i   (we),
    .waddr_i(s2_addr_q),
    .wdata_i(merged)
  );

  assign pool_out = out_q;
  assign pool_out_valid = valid_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_pool_window_unit.sv
// Randomised bench for pool_window_unit against a window-level model.
// Build with POOL_AVG_EN to cover average pooling as well.
module tb_pool_window_unit;
  import pool_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic line_buffer_reset = 1'b0;
  logic pool_enable = 1'b0;
  logic shift_in = 1'b0;
  logic signed [15:0] data_in = '0;
  logic [15:0] row_length = '0;
  logic [3:0] pool_horiz = '0;
  logic [3:0] pool_vert = '0;
`ifdef POOL_AVG_EN
  logic pool_type = 1'b0;
`endif
  logic signed [15:0] pool_out;
  logic pool_out_valid;
  logic cfg_err;

  pool_window_unit dut (
    .clk              (clk),
    .rst              (rst),
    .line_buffer_reset(line_buffer_reset),
    .pool_enable      (pool_enable),
    .shift_in         (shift_in),
    .data_in          (data_in),
    .row_length       (row_length),
    .pool_horiz       (pool_horiz),
    .pool_vert        (pool_vert),
`ifdef POOL_AVG_EN
    .pool_type        (pool_type),
`endif
    .pool_out         (pool_out),
    .pool_out_valid   (pool_out_valid),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc[$];
  int pul_cyc[$];
  int pul_val[$];

  always @(negedge clk) begin
    cyc++;
    if (rst && shift_in && pool_enable && !line_buffer_reset)
      acc_cyc.push_back(cyc);
    if (pool_out_valid) begin
      pul_val.push_back(int'(pool_out));
      pul_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int l, input int h, input int v, input int t);
    tick();
    line_buffer_reset = 1'b1;
    shift_in = 1'b0;
    pool_enable = 1'b1;
    row_length = 16'(l);
    pool_horiz = 4'(h);
    pool_vert = 4'(v);
`ifdef POOL_AVG_EN
    pool_type = (t != 0);
`endif
    tick();
    tick();
    line_buffer_reset = 1'b0;
    if (t < 0) $display("negative pool type ignored");
  endtask

  task automatic run_frame(input int l, input int h, input int v,
                           input int t, input int nrows, input int gap,
                           input int base, input bit rnd);
    logic signed [15:0] px[$];
    logic signed [15:0] tr;
    int ev[$];
    int el[$];
    bit err;
    int m, s, idx, shamt, n;
    load_cfg(l, h, v, t);
    acc_cyc.delete();
    for (int i = 0; i < l * nrows; i++)
      px.push_back(rnd ? 16'($urandom) : 16'(base + i));
    foreach (px[i]) begin
      repeat ($urandom_range(gap, 0)) begin
        tick();
        shift_in = 1'($urandom);
        pool_enable = 1'b0;
        data_in = 16'($urandom);
      end
      tick();
      shift_in = 1'b1;
      pool_enable = 1'b1;
      data_in = px[i];
    end
    tick();
    shift_in = 1'b0;
    repeat (6) tick();

    err = (h == 0) || (v == 0) || (h > 4) || (v > 4) ||
          (l > 256) || (l < h) ||
          ((t != 0) && (((h & (h - 1)) != 0) || ((v & (v - 1)) != 0)));
    chk("cfg_err", int'(cfg_err), int'(err));
    if (!err) begin
      shamt = $clog2(h) + $clog2(v);
      for (int vg = 0; (vg + 1) * v <= nrows; vg++) begin
        for (int wc = 0; wc < l / h; wc++) begin
          s = 0;
          m = int'(px[vg * v * l + wc * h]);
          idx = 0;
          for (int r = 0; r < v; r++) begin
            for (int c = 0; c < h; c++) begin
              idx = (vg * v + r) * l + wc * h + c;
              s += int'(px[idx]);
              if (int'(px[idx]) > m) m = int'(px[idx]);
            end
          end
          tr = 16'(s >>> shamt);
          ev.push_back((t != 0) ? int'(tr) : m);
          el.push_back(idx);
        end
      end
    end
    chk("pulse_count", pul_val.size(), ev.size());
    n = (pul_val.size() < ev.size()) ? pul_val.size() : ev.size();
    for (int i = 0; i < n; i++) begin
      chk("value", pul_val[i], ev[i]);
      if (el[i] < acc_cyc.size())
        chk("latency", pul_cyc[i] - acc_cyc[el[i]], LAT_POOL);
      else
        chk("accept_seen", acc_cyc.size(), el[i] + 1);
    end
    pul_val.delete();
    pul_cyc.delete();
  endtask

  initial begin
    int l, h, v, t;
    repeat (2) tick();
    chk("rst_out", int'(pool_out), 0);
    chk("rst_valid", int'(pool_out_valid), 0);
    chk("rst_err", int'(cfg_err), 0);
    rst = 1'b1;

    run_frame(4, 2, 2, 0, 4, 0, 0, 1'b0);
    run_frame(4, 2, 2, 0, 2, 0, -8, 1'b0);
    run_frame(5, 2, 2, 0, 2, 0, 1, 1'b0);
    run_frame(4, 2, 2, 0, 4, 3, 0, 1'b0);

    // Abandon a frame after six pixels; its first window must be flushed
    load_cfg(4, 2, 2, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      shift_in = 1'b1;
      data_in = 16'(i);
    end
    tick();
    shift_in = 1'b0;
    line_buffer_reset = 1'b1;
    run_frame(4, 2, 2, 0, 4, 0, 0, 1'b0);

    // Async reset in the middle of a frame
    load_cfg(4, 2, 2, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      shift_in = 1'b1;
      data_in = 16'(i + 20);
    end
    tick();
    shift_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_out", int'(pool_out), 0);
    chk("midrst_valid", int'(pool_out_valid), 0);
    tick();
    tick();
    rst = 1'b1;
    chk("midrst_nopulse", pul_val.size(), 0);
    run_frame(4, 2, 2, 0, 4, 0, 0, 1'b0);

    run_frame(4, 0, 2, 0, 4, 0, 0, 1'b0);
    run_frame(3, 4, 2, 0, 2, 0, 0, 1'b1);
    run_frame(8, 5, 2, 0, 2, 0, 0, 1'b1);
    run_frame(300, 2, 1, 0, 1, 0, 0, 1'b1);

    run_frame(1, 1, 2, 0, 6, 0, 0, 1'b1);
    run_frame(1, 1, 3, 0, 7, 1, 0, 1'b1);
    run_frame(4, 1, 1, 0, 2, 0, 0, 1'b1);
    run_frame(6, 3, 3, 0, 6, 2, 0, 1'b1);

`ifdef POOL_AVG_EN
    run_frame(4, 2, 2, 1, 4, 0, 0, 1'b0);
    run_frame(6, 3, 2, 1, 2, 0, 0, 1'b1);
    run_frame(8, 4, 4, 1, 4, 1, 0, 1'b1);
`endif

    for (int k = 0; k < 20; k++) begin
      h = $urandom_range(4, 1);
      v = $urandom_range(4, 1);
      l = $urandom_range(12, 1);
      t = 0;
`ifdef POOL_AVG_EN
      t = $urandom_range(1, 0);
`endif
      run_frame(l, h, v, t, $urandom_range(6, 1), $urandom_range(3, 0),
                0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pool_window_unit.md
Name: pool_window_unit

Overview:
- Per-PE streaming pooling datapath. It is the responder to the pool sequencer's PE-array control: it consumes the per-PE shift strobe and pixel stream in raster order.
- Reduces each pool_vert x pool_horiz window to one value and emits it with fixed latency, for write-back into BUF2.
- One instance per PE lane; instantiated N_PE times inside the PE array.

Parameters:
- DATA_W, 16, pixel width (signed two's complement)
- MAX_ROW, 256, max row_length; depth of the partial-result row memory
- MAX_POOL, 4, max pool_horiz / pool_vert
- LAT_POOL, 2, cycles from last window pixel accepted to pool_out_valid

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- line_buffer_reset  in  1  synchronous clear of counters; config latched on its falling edge
- pool_enable  in  1  block enable; shift_in ignored when 0
- shift_in  in  1  pixel strobe, one pixel per asserted cycle
- data_in  in  DATA_W  pixel, signed
- row_length  in  16  input row width (pool__data_wid)
- pool_horiz  in  4  window width
- pool_vert  in  4  window height
- pool_out  out  DATA_W  pooled result
- pool_out_valid  out  1  one-cycle pulse per result
- cfg_err  out  1  latched configuration error

Behaviour:
- Reset (rst=0): pool_out=0, pool_out_valid=0, cfg_err=0, all counters 0, pipeline valids 0. Row memory is not cleared.
- Config is latched on the cycle line_buffer_reset goes 1->0 and held until the next line_buffer_reset. Live input changes mid-frame have no effect.
- cfg_err=1 if any of the following holds: pool_horiz=0; pool_vert=0; pool_horiz>MAX_POOL; pool_vert>MAX_POOL; row_length>MAX_ROW; row_length<pool_horiz. While cfg_err=1, pool_out_valid is held 0. cfg_err is cleared at the next latch.
- line_buffer_reset=1: col, hcnt, wcol and vcnt go to 0, and pipeline valids are flushed. It takes priority over a simultaneous shift_in.
- Accepted pixel = shift_in & pool_enable & !line_buffer_reset & !cfg_err.
- Counters, updated per accepted pixel:
  - col: 0..row_length-1.
  - hcnt: 0..pool_horiz-1; also resets to 0 when col wraps.
  - wcol: increments on hcnt wrap; resets on col wrap.
  - vcnt: increments on col wrap, wraps at pool_vert-1.
- out_wid = row_length / pool_horiz, by integer division.
- Pixels with wcol >= out_wid (trailing columns) are accepted but discarded. Trailing rows beyond out_hei*pool_vert are the sequencer's concern; the block keeps cycling.
- Stage 1 (accept cycle): horizontal partial hmax = data_in when hcnt=0, else signed max(hmax, data_in). Gaps between strobes (bubbles) hold all state.
- Stage 2 (cycle after a pixel with hcnt=pool_horiz-1 and wcol<out_wid):
  - read-modify-write of row_mem[wcol]; when vcnt=0 the value is written, not merged.
  - If vcnt=pool_vert-1, the merged result goes to the output register instead of memory.
- pool_out_valid pulses exactly LAT_POOL cycles after the accept cycle of the window's final pixel. pool_out holds its last value between pulses.
- Back-to-back windows (pool_horiz=1) produce consecutive pulses with no stall. The row_mem read and write addresses differ or are forwarded, so there is no hazard.
- pool_enable=0 mid-frame behaves as bubbles: state is retained and there is no output.
- Async reset mid-frame: immediate return to reset values. A later frame requires line_buffer_reset before data.

Optional Feature:
- Macro POOL_AVG_EN.
- Defined:
  - Adds input port pool_type (1 bit): 0=max, 1=average.
  - Average accumulates a sum of width DATA_W+4, then arithmetic-shifts right by log2(pool_horiz)+log2(pool_vert) and truncates to DATA_W.
  - A non-power-of-two window with pool_type=1 sets cfg_err.
  - pool_type is latched with the rest of the config.
- Undefined: no pool_type port; max pooling only; row_mem width DATA_W.

Decomposition:
- Shared package pool_pkg holds:
  - localparams for the default DATA_W, MAX_ROW, MAX_POOL and LAT_POOL (LAT_POOL must equal the sequencer's LAT_POOL);
  - typedef pool_cfg_t {row_length, pool_horiz, pool_vert[, pool_type]};
  - enum pool_type_e {POOL_MAX, POOL_AVG}.
- One natural sub-module, pool_row_mem: a 1R1W MAX_ROW-deep row memory with write-to-read forwarding.

Test Plan:
- 4x4 frame, values 0..15 row-major, 2x2 max, row_length=4 -> four pulses, values 5, 7, 13, 15, each exactly 2 cycles after the accept of pixels 5, 7, 13, 15.
- All-negative frame -8..-1, 2x2, row_length=4 (2 rows) -> results -3, -1 (signed compare).
- row_length=5, pool 2x2, 2 rows of 1..10 -> results 7, 9; column-5 pixels do not affect output.
- Same 4x4 stimulus with random 0-3 cycle gaps between shift_in -> identical values and count; each pulse is 2 cycles after its last pixel.
- Config and reset cases:
  - line_buffer_reset asserted after 6 pixels, then a clean 4x4 frame -> results 5, 7, 13, 15 only.
  - pool_horiz=0 -> cfg_err=1, no pulses.
- POOL_AVG_EN, pool_type=1, 2x2 on 0..15 -> 2, 4, 10, 12; 3x2 window -> cfg_err=1.
